// File: rtl/alu_botonera_secuencial.sv
// Board-level ALU front end: debounced buttons load operands/opcode from the switches
// and launch a registered execution whose result and flags drive the LEDs.
module alu_botonera_secuencial #(
    parameter int NB_DATA         = 8,
    parameter int CANT_BOTONES    = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NB_DATA-1:0]      i_switches,
    input  logic [CANT_BOTONES-1:0] i_botones,
    output logic [NB_DATA-1:0]      o_leds,
    output logic                    o_carry,
    output logic                    o_zero,
    output logic                    o_overflow,
    output logic                    o_valid,
    output logic                    o_error
);

    localparam int                 CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB_DATA-1:0] SHIFT_LIM = NB_DATA'(NB_DATA);
    localparam int                 MSB       = NB_DATA - 1;

    localparam int BTN_A    = 0;
    localparam int BTN_B    = 1;
    localparam int BTN_OP   = 2;
    localparam int BTN_EXEC = 3;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    logic [NB_DATA-1:0]      sw_meta_r;
    logic [NB_DATA-1:0]      sw_sync_r;
    logic [CANT_BOTONES-1:0] btn_meta_r;
    logic [CANT_BOTONES-1:0] btn_sync_r;
    logic [CANT_BOTONES-1:0] btn_db_r;
    logic [CANT_BOTONES-1:0] btn_db_prev_r;
    logic [CANT_BOTONES-1:0] btn_str_r;
    logic [CNT_W-1:0]        btn_cnt_r [CANT_BOTONES];

    logic [NB_DATA-1:0] a_r;
    logic [NB_DATA-1:0] b_r;
    logic [5:0]         op_r;
    logic               va_r;
    logic               vb_r;
    logic               vop_r;
    state_t             state_r;
    logic [NB_DATA-1:0] ex_a_r;
    logic [NB_DATA-1:0] ex_b_r;
    logic [5:0]         ex_op_r;

    logic [NB_DATA:0]   sum_s;
    logic [NB_DATA-1:0] alu_res_s;
    logic               alu_carry_s;
    logic               alu_ovf_s;
    logic               alu_ok_s;

    // Two-flop synchronisers for the asynchronous switch bank.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sw_meta_r <= '0;
            sw_sync_r <= '0;
        end else begin
            sw_meta_r <= i_switches;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Per-button synchroniser, debounce counter and rising-edge strobe.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            btn_meta_r    <= '0;
            btn_sync_r    <= '0;
            btn_db_r      <= '0;
            btn_db_prev_r <= '0;
            btn_str_r     <= '0;
            for (int i = 0; i < CANT_BOTONES; i++) begin
                btn_cnt_r[i] <= '0;
            end
        end else begin
            btn_meta_r    <= i_botones;
            btn_sync_r    <= btn_meta_r;
            btn_db_prev_r <= btn_db_r;
            btn_str_r     <= btn_db_r & ~btn_db_prev_r;
            for (int i = 0; i < CANT_BOTONES; i++) begin
                if (btn_sync_r[i] != btn_db_r[i]) begin
                    // Accept the new level only after a full run of differing samples.
                    if (btn_cnt_r[i] == CNT_LAST) begin
                        btn_db_r[i]  <= ~btn_db_r[i];
                        btn_cnt_r[i] <= '0;
                    end else begin
                        btn_cnt_r[i] <= btn_cnt_r[i] + CNT_W'(1);
                    end
                end else begin
                    btn_cnt_r[i] <= '0;
                end
            end
        end
    end

    // ALU datapath on the operands latched at entry to EXEC.
    always_comb begin
        sum_s       = '0;
        alu_res_s   = '0;
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        alu_ok_s    = 1'b1;
        case (ex_op_r)
            OP_ADD: begin
                sum_s       = {1'b0, ex_a_r} + {1'b0, ex_b_r};
                alu_res_s   = sum_s[NB_DATA-1:0];
                alu_carry_s = sum_s[NB_DATA];
                alu_ovf_s   = (ex_a_r[MSB] == ex_b_r[MSB]) && (alu_res_s[MSB] != ex_a_r[MSB]);
            end
            OP_SUB: begin
                // The extra top bit of the widened difference is the borrow.
                sum_s       = {1'b0, ex_a_r} - {1'b0, ex_b_r};
                alu_res_s   = sum_s[NB_DATA-1:0];
                alu_carry_s = sum_s[NB_DATA];
                alu_ovf_s   = (ex_a_r[MSB] != ex_b_r[MSB]) && (alu_res_s[MSB] != ex_a_r[MSB]);
            end
            OP_AND: alu_res_s = ex_a_r & ex_b_r;
            OP_OR:  alu_res_s = ex_a_r | ex_b_r;
            OP_XOR: alu_res_s = ex_a_r ^ ex_b_r;
            OP_NOR: alu_res_s = ~(ex_a_r | ex_b_r);
            OP_SRL: begin
                if (ex_b_r >= SHIFT_LIM) begin
                    alu_res_s = '0;
                end else begin
                    alu_res_s = ex_a_r >> ex_b_r;
                end
            end
            OP_SRA: begin
                if (ex_b_r >= SHIFT_LIM) begin
                    alu_res_s = {NB_DATA{ex_a_r[MSB]}};
                end else begin
                    alu_res_s = $unsigned($signed(ex_a_r) >>> ex_b_r);
                end
            end
            default: alu_ok_s = 1'b0;
        endcase
    end

    // Operand loads, IDLE/EXEC control and registered result outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            a_r        <= '0;
            b_r        <= '0;
            op_r       <= '0;
            va_r       <= 1'b0;
            vb_r       <= 1'b0;
            vop_r      <= 1'b0;
            state_r    <= ST_IDLE;
            ex_a_r     <= '0;
            ex_b_r     <= '0;
            ex_op_r    <= '0;
            o_leds     <= '0;
            o_carry    <= 1'b0;
            o_zero     <= 1'b0;
            o_overflow <= 1'b0;
            o_valid    <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_error <= 1'b0;
            if (btn_str_r[BTN_A]) begin
                a_r  <= sw_sync_r;
                va_r <= 1'b1;
            end
            if (btn_str_r[BTN_B]) begin
                b_r  <= sw_sync_r;
                vb_r <= 1'b1;
            end
            if (btn_str_r[BTN_OP]) begin
                op_r  <= sw_sync_r[5:0];
                vop_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    // Snapshot pre-edge operands so a concurrent load cannot leak in.
                    if (btn_str_r[BTN_EXEC]) begin
                        if (va_r && vb_r && vop_r) begin
                            ex_a_r  <= a_r;
                            ex_b_r  <= b_r;
                            ex_op_r <= op_r;
                            state_r <= ST_EXEC;
                        end else begin
                            o_error <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    state_r <= ST_IDLE;
                    if (alu_ok_s) begin
                        o_leds     <= alu_res_s;
                        o_carry    <= alu_carry_s;
                        o_overflow <= alu_ovf_s;
                        o_zero     <= (alu_res_s == '0);
                        o_valid    <= 1'b1;
                    end else begin
                        o_error <= 1'b1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_botonera_secuencial.sv
// Randomised and directed bench for alu_botonera_secuencial with a short debounce window.
module tb_alu_botonera_secuencial;

    localparam int NB  = 8;
    localparam int DEB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] sw;
    logic [3:0]    btn;
    logic [NB-1:0] leds;
    logic          carry, zero, ovf, valid, err;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations collected by run_exec.
    int ob_valid, ob_err, ob_dvalid, ob_derr, ob_str;

    // Reference state for the randomised scenario.
    logic [NB-1:0] m_leds;
    logic          m_c, m_z, m_v;

    alu_botonera_secuencial #(
        .NB_DATA(NB),
        .CANT_BOTONES(4),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .i_switches(sw),
        .i_botones(btn),
        .o_leds(leds),
        .o_carry(carry),
        .o_zero(zero),
        .o_overflow(ovf),
        .o_valid(valid),
        .o_error(err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int idx, input logic [NB-1:0] val);
        sw = val;
        tick(3);
        btn[idx] = 1'b1;
        tick(9);
        btn[idx] = 1'b0;
        tick(10);
    endtask

    task automatic run_exec(input logic [3:0] mask);
        ob_valid = 0; ob_err = 0; ob_dvalid = -1; ob_derr = -1; ob_str = -1;
        btn = mask;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 10) btn = 4'b0000;
            if (dut.btn_str_r[3] && ob_str < 0) ob_str = k;
            if (valid) begin
                ob_valid++;
                if (ob_str >= 0) ob_dvalid = k - ob_str;
            end
            if (err) begin
                ob_err++;
                if (ob_str >= 0) ob_derr = k - ob_str;
            end
        end
    endtask

    // Opcode semantics computed with plain integer arithmetic.
    function automatic void model(input int a, input int b, input int op,
                                  output logic ok, output logic [NB-1:0] r,
                                  output logic c, output logic z, output logic v);
        int sa, sb;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        ok = 1'b1; c = 1'b0; v = 1'b0; r = 8'h00;
        case (op)
            32: begin r = 8'(a + b); c = (a + b) > 255; v = (sa + sb > 127) || (sa + sb < -128); end
            34: begin r = 8'(a - b); c = a < b;         v = (sa - sb > 127) || (sa - sb < -128); end
            36: r = 8'(a & b);
            37: r = 8'(a | b);
            38: r = 8'(a ^ b);
            39: r = 8'(~(a | b));
            2:  r = (b >= 8) ? 8'h00 : 8'(a >> b);
            3:  r = (b >= 8) ? ((sa < 0) ? 8'hFF : 8'h00) : 8'(sa >>> b);
            default: ok = 1'b0;
        endcase
        z = (r == 8'h00);
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; btn = 4'b0000; sw = 8'hA5;
        tick(3);
        n_checks++;
        if ({leds, carry, zero, ovf, valid, err} !== 13'd0)
            $display("FAIL reset_held: got %h/%b%b%b%b%b want all zero", leds, carry, zero, ovf, valid, err);
        else n_pass++;
        rst_n = 1'b1;
        tick(5);
        n_checks++;
        if ({leds, carry, zero, ovf, valid, err, dut.btn_str_r} !== 17'd0)
            $display("FAIL reset_released: got %h/%b%b%b%b%b want all zero", leds, carry, zero, ovf, valid, err);
        else n_pass++;
    endtask

    task automatic test_debounce;
        int first, cnt;
        first = -1; cnt = 0;
        sw = 8'h00;
        btn[0] = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (dut.btn_str_r[0]) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        n_checks++;
        if (first !== 7) $display("FAIL strobe_latency: got %0d want 7", first);
        else n_pass++;
        n_checks++;
        if (cnt !== 1) $display("FAIL strobe_held_count: got %0d want 1", cnt);
        else n_pass++;
        btn[0] = 1'b0; cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dut.btn_str_r[0]) cnt++;
        end
        n_checks++;
        if (cnt !== 0) $display("FAIL strobe_on_release: got %0d want 0", cnt);
        else n_pass++;
        cnt = 0;
        for (int r = 0; r < 6; r++) begin
            btn[0] = 1'b1;
            for (int k = 0; k < 3; k++) begin @(negedge clk); if (dut.btn_str_r[0]) cnt++; end
            btn[0] = 1'b0;
            for (int k = 0; k < 3; k++) begin @(negedge clk); if (dut.btn_str_r[0]) cnt++; end
        end
        for (int k = 0; k < 8; k++) begin @(negedge clk); if (dut.btn_str_r[0]) cnt++; end
        n_checks++;
        if (cnt !== 0) $display("FAIL bounce_strobe: got %0d want 0", cnt);
        else n_pass++;
    endtask

    task automatic test_add;
        load(0, 8'h7F); load(1, 8'h01); load(2, 8'h20);
        run_exec(4'b1000);
        n_checks++;
        if ({leds, carry, zero, ovf} !== {8'h80, 1'b0, 1'b0, 1'b1})
            $display("FAIL add_7f_01: got %h c%b z%b v%b want 80 c0 z0 v1", leds, carry, zero, ovf);
        else n_pass++;
        n_checks++;
        if (ob_valid !== 1 || ob_dvalid !== 2 || ob_err !== 0)
            $display("FAIL add_valid_timing: got n=%0d lat=%0d err=%0d want 1/2/0", ob_valid, ob_dvalid, ob_err);
        else n_pass++;
    endtask

    task automatic test_sub;
        load(0, 8'h05); load(1, 8'h07); load(2, 8'h22);
        run_exec(4'b1000);
        n_checks++;
        if ({leds, carry, zero, ovf, ob_valid[0]} !== {8'hFE, 1'b1, 1'b0, 1'b0, 1'b1})
            $display("FAIL sub_borrow: got %h c%b z%b v%b n=%0d want fe c1 z0 v0 n=1", leds, carry, zero, ovf, ob_valid);
        else n_pass++;
        load(0, 8'h07);
        run_exec(4'b1000);
        n_checks++;
        if ({leds, carry, zero, ovf, ob_valid[0]} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b1})
            $display("FAIL sub_zero: got %h c%b z%b v%b n=%0d want 00 c0 z1 v0 n=1", leds, carry, zero, ovf, ob_valid);
        else n_pass++;
    endtask

    task automatic test_shift;
        load(0, 8'h90); load(1, 8'h02); load(2, 8'h03);
        run_exec(4'b1000);
        n_checks++;
        if ({leds, carry, zero, ovf} !== {8'hE4, 3'b000})
            $display("FAIL sra_by_2: got %h c%b z%b v%b want e4 000", leds, carry, zero, ovf);
        else n_pass++;
        load(1, 8'h09);
        run_exec(4'b1000);
        n_checks++;
        if ({leds, carry, zero, ovf} !== {8'hFF, 3'b000})
            $display("FAIL sra_by_9: got %h c%b z%b v%b want ff 000", leds, carry, zero, ovf);
        else n_pass++;
        load(2, 8'h02);
        run_exec(4'b1000);
        n_checks++;
        if ({leds, carry, zero, ovf} !== {8'h00, 3'b010})
            $display("FAIL srl_by_9: got %h c%b z%b v%b want 00 010", leds, carry, zero, ovf);
        else n_pass++;
    endtask

    task automatic test_errors;
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
        load(0, 8'h33);
        run_exec(4'b1000);
        n_checks++;
        if (ob_err !== 1 || ob_derr !== 1 || ob_valid !== 0 || leds !== 8'h00)
            $display("FAIL exec_missing_operands: got err=%0d lat=%0d val=%0d leds=%h want 1/1/0/00", ob_err, ob_derr, ob_valid, leds);
        else n_pass++;
        load(1, 8'h01); load(2, 8'h20);
        run_exec(4'b1000);
        n_checks++;
        if (leds !== 8'h34 || ob_valid !== 1)
            $display("FAIL exec_after_loads: got %h n=%0d want 34 n=1", leds, ob_valid);
        else n_pass++;
        load(2, 8'h3F);
        run_exec(4'b1000);
        n_checks++;
        if (ob_err !== 1 || ob_derr !== 2 || ob_valid !== 0)
            $display("FAIL unknown_op_pulse: got err=%0d lat=%0d val=%0d want 1/2/0", ob_err, ob_derr, ob_valid);
        else n_pass++;
        n_checks++;
        if ({leds, carry, zero, ovf} !== {8'h34, 3'b000})
            $display("FAIL unknown_op_hold: got %h c%b z%b v%b want 34 000", leds, carry, zero, ovf);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        load(0, 8'h01); load(1, 8'h01); load(2, 8'h20);
        sw = 8'h10;
        tick(3);
        run_exec(4'b1010);
        n_checks++;
        if (leds !== 8'h02 || ob_valid !== 1)
            $display("FAIL same_cycle_load: got %h n=%0d want 02 n=1", leds, ob_valid);
        else n_pass++;
        run_exec(4'b1000);
        n_checks++;
        if (leds !== 8'h11 || ob_valid !== 1)
            $display("FAIL reexecute: got %h n=%0d want 11 n=1", leds, ob_valid);
        else n_pass++;
    endtask

    task automatic test_reset_exec;
        int seen, saw_valid, nonzero;
        seen = 0; saw_valid = 0; nonzero = 0;
        btn[3] = 1'b1;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (dut.btn_str_r[3]) seen = 1;
        end
        n_checks++;
        if (seen !== 1) $display("FAIL exec_strobe_timeout: got %0d want 1", seen);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        btn = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (valid) saw_valid++;
            if ({leds, carry, zero, ovf, err} !== 12'd0) nonzero++;
        end
        n_checks++;
        if (saw_valid !== 0 || nonzero !== 0)
            $display("FAIL reset_in_exec: got valid=%0d nonzero=%0d want 0/0", saw_valid, nonzero);
        else n_pass++;
        rst_n = 1'b1;
        tick(12);
        run_exec(4'b1000);
        n_checks++;
        if (ob_err !== 1 || ob_valid !== 0 || leds !== 8'h00)
            $display("FAIL state_cleared: got err=%0d val=%0d leds=%h want 1/0/00", ob_err, ob_valid, leds);
        else n_pass++;
    endtask

    task automatic test_random;
        int ops [10] = '{32, 34, 36, 37, 38, 39, 2, 3, 33, 63};
        int a, b, op;
        logic ok, c, z, v;
        logic [NB-1:0] r;
        m_leds = 8'h00; m_c = 1'b0; m_z = 1'b0; m_v = 1'b0;
        for (int it = 0; it < 14; it++) begin
            a  = $urandom_range(0, 255);
            op = ops[$urandom_range(0, 9)];
            b  = (op == 2 || op == 3) ? $urandom_range(0, 10) : $urandom_range(0, 255);
            load(0, 8'(a));
            load(1, 8'(b));
            load(2, {2'($urandom_range(0, 3)), 6'(op)});
            run_exec(4'b1000);
            model(a, b, op, ok, r, c, z, v);
            if (ok) begin
                m_leds = r; m_c = c; m_z = z; m_v = v;
            end
            n_checks++;
            if ({leds, carry, zero, ovf} !== {m_leds, m_c, m_z, m_v})
                $display("FAIL rand_result it%0d a=%h b=%h op=%0d: got %h %b%b%b want %h %b%b%b",
                         it, a, b, op, leds, carry, zero, ovf, m_leds, m_c, m_z, m_v);
            else n_pass++;
            n_checks++;
            if (ok ? (ob_valid !== 1 || ob_dvalid !== 2 || ob_err !== 0)
                   : (ob_valid !== 0 || ob_err !== 1 || ob_derr !== 2))
                $display("FAIL rand_handshake it%0d op=%0d: got val=%0d/%0d err=%0d/%0d want ok=%0d",
                         it, op, ob_valid, ob_dvalid, ob_err, ob_derr, ok);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; btn = 4'b0000; sw = 8'h00;
        test_reset;
        test_debounce;
        test_add;
        test_sub;
        test_shift;
        test_errors;
        test_back_to_back;
        test_reset_exec;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_botonera_secuencial.md
Name: alu_botonera_secuencial

Overview:
Parametrised successor of the board-level ALU wrapper: a switch/button front end with debounced, edge-detected buttons. Operand A, operand B and the opcode are each captured from the switches by a dedicated button, and a fourth button starts a registered execution. The block drives the result LEDs plus flag, valid and error outputs.
It sits directly under the top level, between the board I/O and the LEDs.

Parameters:
NB_DATA, 8, operand/result/switch width; must be >= 6 (opcode is taken from switches[5:0])
CANT_BOTONES, 4, number of buttons; fixed function map below, must be 4
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a button change; must be >= 2

Ports:
i_clock  in  1  system clock; single clock domain
i_reset  in  1  asynchronous, active-low reset
i_switches  in  NB_DATA  operand/opcode switches (asynchronous)
i_botones  in  CANT_BOTONES  raw buttons (asynchronous, bouncing): [0] load A, [1] load B, [2] load opcode, [3] execute
o_leds  out  NB_DATA  registered result
o_carry  out  1  carry/borrow flag of the last valid execution
o_zero  out  1  result==0 flag of the last valid execution
o_overflow  out  1  signed overflow flag of the last valid execution
o_valid  out  1  one-cycle pulse: new result on o_leds
o_error  out  1  one-cycle pulse: execute rejected

Behaviour:
- Reset (i_reset=0, asynchronous): all registers clear.
  - A=0, B=0, OP=0; valid bits vA=vB=vOP=0.
  - All outputs 0; debounce counters 0; debounced states 0; synchronisers 0.
- Input path, per button, independent:
  - 2-FF synchroniser, then debounce counter.
  - The counter increments while the synchronised value differs from the debounced state and clears when it matches.
  - On the DEBOUNCE_CYCLES-th consecutive differing sample, the debounced state toggles and the counter clears.
  - Strobe = debounced & ~debounced_prev (registered): exactly one cycle per accepted press. Release produces no strobe.
  - Latency: edge N is the first edge sampling raw=1 with raw held stable. The debounced state goes to 1 at edge N+DEBOUNCE_CYCLES+1. The strobe is high for the cycle following edge N+DEBOUNCE_CYCLES+2.
  - Glitches shorter than DEBOUNCE_CYCLES samples produce no strobe.
- Switches are sampled through a 2-FF synchroniser; loads use the synchronised value.
- Load strobes:
  - str0: A<=sw, vA<=1.
  - str1: B<=sw, vB<=1.
  - str2: OP<=sw[5:0], vOP<=1.
  - Simultaneous load strobes all take effect in the same cycle.
- FSM states: IDLE, EXEC.
  - IDLE + str3 with vA&vB&vOP=1 (pre-edge values) -> EXEC.
  - IDLE + str3 with any valid bit 0 -> stay IDLE, o_error=1 for one cycle, outputs unchanged.
  - EXEC -> IDLE unconditionally after one cycle. In EXEC: o_leds and flags update at the edge leaving EXEC, and o_valid=1 in the following cycle.
  - Result latency: 2 cycles after the execute strobe cycle.
- Execute uses A/B/OP as registered at entry to EXEC. A load in the same cycle as str3 does not affect that execution.
- str3 while in EXEC is ignored: no error, no queue.
- Valid bits persist after execution; re-execute is allowed without reloading.
- Opcodes (OP[5:0]), N=NB_DATA, all results mod 2^N:
  - 100000 ADD: carry=carry-out; overflow=signed overflow.
  - 100010 SUB (A-B): carry=1 iff A<B unsigned (borrow); overflow=signed overflow.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR: carry=0, overflow=0.
  - 000010 SRL (A>>B): 0 if B>=N; carry=0, overflow=0.
  - 000011 SRA (A>>>B): all sign bits if B>=N; carry=0, overflow=0.
  - Any other OP: result, flags and o_leds hold; o_valid=0; o_error=1 in the cycle o_valid would have pulsed.
- o_zero = (result==0) on valid executions only.
- Reset asserted mid-debounce or mid-EXEC aborts immediately: no o_valid, all state cleared.

Test Plan:
- DEBOUNCE_CYCLES=4, NB_DATA=8: raw button 0 high, stable -> single strobe exactly at edge N+6. Bouncing pulses of 3 cycles -> no strobe. Held 100 cycles -> exactly one strobe.
- Load A=0x7F, B=0x01, OP=100000, execute -> o_leds=0x80, overflow=1, carry=0, zero=0. o_valid pulses 2 cycles after the strobe.
- A=0x05, B=0x07, OP=100010 -> o_leds=0xFE, carry=1, overflow=0. Then A=0x07, same B/OP -> 0x00, zero=1.
- SRA: A=0x90, B=0x02 -> 0xE4. B=0x09 -> 0xFF. SRL: A=0x90, B=0x09 -> 0x00.
- After reset, execute with only A loaded -> o_error pulse, o_leds=0. Unknown OP=111111 after a valid result -> o_error pulse, o_leds unchanged.
- str1 (B=0x10) and str3 in the same cycle with prior B=0x01, A=0x01, ADD -> o_leds=0x02. Re-execute -> 0x11. Reset asserted during EXEC -> no o_valid, all outputs 0.
